// File: rtl/elastic_stage_regs.sv
// Elastic pipeline stage register carrying {pc, instruction} with a valid/ready handshake,
// synchronous flush that leaves a NOP bubble on the outputs, and an optional skid entry.
module elastic_stage_regs #(
    parameter int                    PC_WIDTH   = 33,
    parameter int                    DATA_WIDTH = 32,
    parameter bit                    SKID       = 1'b1,
    parameter logic [DATA_WIDTH-1:0] BUBBLE     = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PC_WIDTH-1:0]   in_pc,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_WIDTH-1:0]   out_pc,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [1:0]            occupancy
);

    // state      | meaning
    // ST_EMPTY   | no entry held, outputs show the bubble
    // ST_FULL    | main entry M drives the outputs
    // ST_SKIDDED | M plus overflow entry S (SKID=1 only), upstream stalled
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FULL    = 2'd1;
    localparam logic [1:0] ST_SKIDDED = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [PC_WIDTH-1:0]   m_pc_q, s_pc_q;
    logic [DATA_WIDTH-1:0] m_data_q, s_data_q;
    logic                  in_xfer, out_xfer;
    logic                  m_load_in, m_load_skid, s_load;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = out_valid & out_ready;
    assign occupancy = state_q;
    assign out_pc    = out_valid ? m_pc_q : '0;
    assign out_data  = out_valid ? m_data_q : BUBBLE;

    always_comb begin
        state_d     = state_q;
        m_load_in   = 1'b0;
        m_load_skid = 1'b0;
        s_load      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (in_xfer) begin
                    state_d   = ST_FULL;
                    m_load_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_xfer && in_xfer) begin
                    m_load_in = 1'b1;
                end else if (out_xfer) begin
                    state_d = ST_EMPTY;
                end else if (in_xfer && SKID) begin
                    state_d = ST_SKIDDED;
                    s_load  = 1'b1;
                end
            end
            ST_SKIDDED: begin
                if (out_xfer) begin
                    state_d     = ST_FULL;
                    m_load_skid = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any load; a simultaneous out-xfer has already completed.
        if (flush) begin
            state_d     = ST_EMPTY;
            m_load_in   = 1'b0;
            m_load_skid = 1'b0;
            s_load      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc_q   <= '0;
            m_data_q <= BUBBLE;
            s_pc_q   <= '0;
            s_data_q <= BUBBLE;
        end else begin
            if (m_load_in) begin
                m_pc_q   <= in_pc;
                m_data_q <= in_data;
            end else if (m_load_skid) begin
                m_pc_q   <= s_pc_q;
                m_data_q <= s_data_q;
            end
            if (s_load) begin
                s_pc_q   <= in_pc;
                s_data_q <= in_data;
            end
        end
    end

    if (SKID) begin : g_skid
        // Registered ready breaks the out_ready -> in_ready timing path.
        logic in_ready_q;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                in_ready_q <= 1'b1;
            end else begin
                in_ready_q <= (state_d != ST_SKIDDED);
            end
        end
        assign in_ready = in_ready_q;
    end else begin : g_noskid
        assign in_ready = (state_q == ST_EMPTY) | out_ready;
    end

    // Upstream must hold a stalled offer; a flush releases it.
    a_in_stable: assert property (@(posedge clk) disable iff (!rst)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_pc) && $stable(in_data)));

endmodule

// File: tb/tb_elastic_stage_regs.sv
// Scoreboard bench for elastic_stage_regs: one SKID=1 and one SKID=0 instance,
// exercised one at a time with directed sequences followed by random valid/ready traffic.
module tb_elastic_stage_regs;

    localparam int             PW  = 33;
    localparam int             DW  = 32;
    localparam logic [DW-1:0]  NOP = 32'h00000013;
    localparam int             NRAND = 10000;

    typedef struct packed {
        logic [PW-1:0] pc;
        logic [DW-1:0] data;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_pc = '0;
    logic [DW-1:0] in_data = '0;
    logic          sel = 1'b1;

    logic          ir1, ov1, ir0, ov0;
    logic [PW-1:0] pc1, pc0;
    logic [DW-1:0] d1, d0;
    logic [1:0]    occ1, occ0;

    logic          in_ready, out_valid;
    logic [PW-1:0] out_pc;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;

    int    n_tests = 0;
    int    n_fail = 0;
    item_t sb_q[$];
    item_t exp_item;
    bit    last_acc = 1'b1;
    bit    last_flush = 1'b0;

    always #5 clk = ~clk;

    elastic_stage_regs #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .SKID(1'b1), .BUBBLE(NOP)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid & sel), .in_ready(ir1), .in_pc(in_pc), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_pc(pc1), .out_data(d1), .occupancy(occ1)
    );

    elastic_stage_regs #(.PC_WIDTH(PW), .DATA_WIDTH(DW), .SKID(1'b0), .BUBBLE(NOP)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid & ~sel), .in_ready(ir0), .in_pc(in_pc), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_pc(pc0), .out_data(d0), .occupancy(occ0)
    );

    assign in_ready  = sel ? ir1  : ir0;
    assign out_valid = sel ? ov1  : ov0;
    assign out_pc    = sel ? pc1  : pc0;
    assign out_data  = sel ? d1   : d0;
    assign occupancy = sel ? occ1 : occ0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s (skid=%0d): got %0h, expected %0h at t=%0t", name, sel, act, exp_v, $time);
        end
    endtask

    // Monitor: every completed out-xfer must match the oldest accepted payload.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'(1));
            if (sb_q.size() != 0) begin
                exp_item = sb_q.pop_front();
                chk("out_pc", 64'(out_pc), 64'(exp_item.pc));
                chk("out_data", 64'(out_data), 64'(exp_item.data));
            end
        end
    end

    task automatic check_state();
        int n;
        n = sb_q.size();
        chk("occupancy", 64'(occupancy), 64'(n));
        chk("out_valid", 64'(out_valid), 64'(n != 0));
        if (!out_valid) begin
            chk("bubble_data", 64'(out_data), 64'(NOP));
            chk("bubble_pc", 64'(out_pc), 64'(0));
        end
        if (sel) chk("in_ready_skid", 64'(in_ready), 64'(n != 2));
        else     chk("in_ready_noskid", 64'(in_ready), 64'((n == 0) || out_ready));
    endtask

    // One clock: record transfers at the negedge, then check state 1 unit after posedge.
    task automatic step();
        item_t it;
        @(negedge clk);
        last_acc   = in_valid && in_ready;
        last_flush = flush;
        if (last_acc && !flush) begin
            it.pc   = in_pc;
            it.data = in_data;
            sb_q.push_back(it);
        end
        @(posedge clk);
        #1;
        if (last_flush) sb_q.delete();
        check_state();
    endtask

    task automatic apply_reset(input logic mode);
        rst = 1'b0;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        sel = mode;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_acc = 1'b1; last_flush = 1'b0;
        check_state();
    endtask

    task automatic put(input int i);
        in_pc    = {1'b1, 32'h0000_1000 + 32'(4 * i)};
        in_data  = 32'hA000_0000 | 32'(i);
        in_valid = 1'b1;
    endtask

    task automatic run_mode(input logic mode);
        apply_reset(mode);

        // Stream of 8 words at full rate.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            put(i);
            step();
        end
        in_valid = 1'b0;
        step(); step();

        if (mode) begin
            // Back-pressure into the skid entry; C must wait.
            out_ready = 1'b0;
            put(20); step();
            put(21); step();
            chk("bp_occ2", 64'(occupancy), 64'(2));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            put(22); step();
            chk("bp_c_held", 64'(last_acc), 64'(0));
            out_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                step();
                if (last_acc) in_valid = 1'b0;
            end
            chk("bp_drained", 64'(occupancy), 64'(0));
        end else begin
            // Combinational ready and replace-in-place.
            out_ready = 1'b0;
            put(30); step();
            put(31);
            #1 chk("ns_stall_ready", 64'(in_ready), 64'(0));
            step();
            out_ready = 1'b1;
            #1 chk("ns_comb_ready", 64'(in_ready), 64'(1));
            step();
            chk("ns_occ_replace", 64'(occupancy), 64'(1));
            chk("ns_data_replace", 64'(out_data), 64'(32'hA000_001F));
            in_valid = 1'b0;
            step(); step();
        end

        // Flush with a simultaneous offer: the offer must never emerge.
        out_ready = 1'b0;
        put(40); step();
        if (mode) begin
            put(41); step();
            put(42);
        end else begin
            put(43);
            out_ready = 1'b1;
        end
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 64'(out_valid), 64'(0));
        chk("flush_data", 64'(out_data), 64'(NOP));
        chk("flush_occ", 64'(occupancy), 64'(0));
        out_ready = 1'b1;
        step(); step();

        // Asynchronous reset in the middle of a cycle.
        out_ready = 1'b0;
        put(50); step();
        put(51);
        #2 rst = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(NOP));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_occ", 64'(occupancy), 64'(0));
        in_valid = 1'b0;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_acc = 1'b1; last_flush = 1'b0;
        check_state();

        // Random traffic honouring the hold-while-stalled rule.
        for (int c = 0; c < NRAND; c++) begin
            if (!(in_valid && !last_acc && !last_flush)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_pc    = {($urandom_range(0, 1) == 1), $urandom};
                in_data  = $urandom;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        chk("rand_drained", 64'(sb_q.size()), 64'(0));
    endtask

    initial begin
        run_mode(1'b1);
        run_mode(1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, got no finish, expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
